alu_issue_stage: RTL and testbench
==================================

// Module: alu_issue_stage
// PURPOSE
//  Producer side of the ALU operation interface. Decodes RV32I OP, OP-IMM, LUI and AUIPC instructions.
//  Presents {operation, Op1, Op2} to the execute-stage ALU through a registered valid/ready pipeline stage.
//  Two-entry skid buffer: full throughput, with o_Ready driven only from flops.
//  Sits between register-file read (decode) and the combinational ALU.
// PARAMETERS
//  WORD_SIZE  32  datapath width (data_t); only 32 supported
// PORTS
//  i_Clk        in   1   clock, rising edge
//  i_Rst_n      in   1   asynchronous active-low reset
//  i_Flush      in   1   synchronous: discard all buffered entries
//  i_Valid      in   1   upstream entry valid
//  o_Ready      out  1   stage can accept (registered)
//  i_Instr      in   32  instruction word
//  i_PC         in   32  instruction address
//  i_Rs1Data    in   32  rs1 value
//  i_Rs2Data    in   32  rs2 value
//  o_Valid      out  1   entry presented to ALU valid
//  i_Ready      in   1   downstream (execute) accepts
//  o_Operation  out  4   ALU op code (alu_pkg encoding)
//  o_Op1, o_Op2 out  32  ALU operands
//  o_Rd         out  5   destination register
//  o_RegWrite   out  1   write-back enable (0 if rd==0 or illegal)
//  o_Illegal    out  1   entry is an unsupported/malformed instruction
// BEHAVIOUR
//  Reset: o_Valid=0, o_Ready=1, o_Operation=ADD(0), o_Op1=o_Op2=0, o_Rd=0, o_RegWrite=0, o_Illegal=0; state EMPTY.
//  Transfer in: i_Valid&&o_Ready. Transfer out: o_Valid&&i_Ready.
//  Latency: 1 cycle from transfer-in to o_Valid when the stage is EMPTY.
//  States: EMPTY (0 entries), ONE (output reg full), TWO (output + skid full).
//   EMPTY: in -> ONE.
//   ONE: in&!out -> TWO; out&!in -> EMPTY; in&out -> ONE with new entry.
//   TWO: out -> ONE; skid moves to output reg.
//  o_Ready = (state!=TWO). Outputs are held stable while o_Valid&&!i_Ready.
//  i_Flush: next state EMPTY and o_Valid=0, including when it coincides with a transfer. Flush wins.
//  Reset asserted mid-operation: all entries dropped immediately (async); outputs take reset values.
//  Decode, per opcode:
//   OP 0110011: Op1=rs1, Op2=rs2.
//    funct7 0000000: f3 -> ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND.
//    funct7 0100000: only f3=000 (SUB) and f3=101 (SRA) are legal.
//   OP-IMM 0010011: Op1=rs1, Op2=sext(instr[31:20]).
//    f3=001 requires funct7 0000000 (SLLI).
//    f3=101: funct7 0000000 is SRLI, 0100000 is SRAI. Op2 = zero-extended shamt instr[24:20].
//   LUI 0110111: op=LUI, Op1=0, Op2={12'b0,instr[31:12]}. The ALU shifts the immediate into place.
//   AUIPC 0010111: op=AUIPC, Op1=PC, Op2={12'b0,instr[31:12]}.
//   Any other opcode or funct combination: o_Illegal=1, op=ADD, Op1=Op2=0, o_RegWrite=0.
//  o_RegWrite = legal && (rd!=0). Arithmetic widths are all 32 bits; no sign-extension beyond 32.
// STRUCTURE
//  Package alu_pkg:
//   typedef logic [31:0] data_t.
//   alu_op_t, 4 bits: ADD=0 SUB=1 SLL=2 SLT=3 SLTU=4 XOR=5 SRL=6 SRA=7 OR=8 AND=9 LUI=10 AUIPC=11.
//   Opcode constants OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC.
//  Sub-module alu_op_decoder: purely combinational; instr/PC/rs data -> issue record.
//  Top: state register, output register, skid register of the issue record.
// TESTING
//  1. Reset, then add x3,x1,x2 (0x002081B3), rs1=5, rs2=7.
//     -> next cycle o_Valid=1, op=ADD, Op1=5, Op2=7, Rd=3, RegWrite=1.
//  2. sub 0x40208133 -> op=SUB. srai 0x4040D093 -> op=SRA, Op2=4.
//     addi x1,x0,-1 (0xFFF00093) -> op=ADD, Op2=0xFFFFFFFF.
//  3. lui x5,0x12345 (0x123452B7) -> op=LUI, Op1=0, Op2=0x00012345.
//     auipc with PC=0x100 -> op=AUIPC, Op1=0x100.
//  4. Backpressure: i_Ready=0, feed 3 entries back-to-back.
//     -> 2 accepted, o_Ready=0 after the 2nd, outputs stable.
//     -> then i_Ready=1: both entries drain in order; no loss or duplication.
//  5. Flush while in TWO, with simultaneous i_Valid -> next cycle o_Valid=0, o_Ready=1; the new entry is dropped.
//  6. Illegal cases: 0x00000073 (SYSTEM), and OP with funct7=0100000, f3=001.
//     -> o_Illegal=1, RegWrite=0. Also: async reset mid-stream clears o_Valid without a clock edge.

Source files
------------

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared types and constants for the ALU issue path.
//   data_t    : 32-bit datapath word
//   alu_op_t  : 4-bit ALU operation code seen by the execute stage
//   issue_t   : one decoded entry {operation, operands, rd, write-back, illegal}
//   OPC_*     : RV32I major opcodes handled by the issue stage
//   baseOp()  : funct3 -> operation for the funct7=0000000 / OP-IMM family
// ---------------------------------------------------------------------------
package alu_pkg;

   typedef logic [31:0] data_t;

   typedef enum logic [3:0] {
      ALU_ADD   = 4'd0,
      ALU_SUB   = 4'd1,
      ALU_SLL   = 4'd2,
      ALU_SLT   = 4'd3,
      ALU_SLTU  = 4'd4,
      ALU_XOR   = 4'd5,
      ALU_SRL   = 4'd6,
      ALU_SRA   = 4'd7,
      ALU_OR    = 4'd8,
      ALU_AND   = 4'd9,
      ALU_LUI   = 4'd10,
      ALU_AUIPC = 4'd11
   } alu_op_t;

   localparam logic [6:0] OPC_OP    = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI   = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC = 7'b0010111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef struct packed {
      alu_op_t     op;
      data_t       op1;
      data_t       op2;
      logic [4:0]  rd;
      logic        regWrite;
      logic        illegal;
   } issue_t;

   // funct3 maps to the same operation for OP (funct7=0) and OP-IMM;
   // the alternate encodings (SUB/SRA) are resolved by the caller.
   function automatic alu_op_t baseOp(input logic [2:0] f3);
      alu_op_t op;
      case (f3)
         3'b000:  op = ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// ---------------------------------------------------------------------------
// alu_op_decoder
// Purely combinational decode of an RV32I OP / OP-IMM / LUI / AUIPC word into
// the ALU operation and its two operands.
//   i_Instr      : instruction word
//   i_PC         : instruction address (Op1 for AUIPC)
//   i_Rs1Data    : rs1 value
//   i_Rs2Data    : rs2 value
//   o_Operation  : alu_op_t code (ADD when illegal)
//   o_Op1/o_Op2  : operands (zero when illegal)
//   o_Rd         : destination register field
//   o_RegWrite   : legal and rd != x0
//   o_Illegal    : unsupported opcode or funct combination
// ---------------------------------------------------------------------------
module alu_op_decoder
   import alu_pkg::*;
(
   input  logic [31:0] i_Instr,
   input  logic [31:0] i_PC,
   input  logic [31:0] i_Rs1Data,
   input  logic [31:0] i_Rs2Data,
   output logic [3:0]  o_Operation,
   output logic [31:0] o_Op1,
   output logic [31:0] o_Op2,
   output logic [4:0]  o_Rd,
   output logic        o_RegWrite,
   output logic        o_Illegal
);

   logic [6:0] w_Opcode;
   logic [2:0] w_F3;
   logic [6:0] w_F7;
   logic       w_Legal;
   alu_op_t    w_Op;
   data_t      w_Op1;
   data_t      w_Op2;

   assign w_Opcode = i_Instr[6:0];
   assign w_F3     = i_Instr[14:12];
   assign w_F7     = i_Instr[31:25];

   // Operands are chosen per opcode first; legality is folded in at the end
   // so an illegal entry always leaves the ALU computing 0 + 0.
   always_comb begin
      w_Legal = 1'b0;
      w_Op    = ALU_ADD;
      w_Op1   = '0;
      w_Op2   = '0;
      case (w_Opcode)
         OPC_OP: begin
            w_Op1 = i_Rs1Data;
            w_Op2 = i_Rs2Data;
            if (w_F7 == F7_BASE) begin
               w_Legal = 1'b1;
               w_Op    = baseOp(w_F3);
            end else if (w_F7 == F7_ALT && w_F3 == 3'b000) begin
               w_Legal = 1'b1;
               w_Op    = ALU_SUB;
            end else if (w_F7 == F7_ALT && w_F3 == 3'b101) begin
               w_Legal = 1'b1;
               w_Op    = ALU_SRA;
            end
         end
         OPC_OPIMM: begin
            w_Op1 = i_Rs1Data;
            w_Op2 = {{20{i_Instr[31]}}, i_Instr[31:20]};
            if (w_F3 == 3'b001) begin
               // Shift amount only; the upper immediate bits are the funct7 field.
               w_Op2   = {27'd0, i_Instr[24:20]};
               w_Legal = (w_F7 == F7_BASE);
               w_Op    = ALU_SLL;
            end else if (w_F3 == 3'b101) begin
               w_Op2   = {27'd0, i_Instr[24:20]};
               w_Legal = (w_F7 == F7_BASE) || (w_F7 == F7_ALT);
               w_Op    = (w_F7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            end else begin
               w_Legal = 1'b1;
               w_Op    = baseOp(w_F3);
            end
         end
         OPC_LUI: begin
            // The ALU shifts the 20-bit immediate into place itself.
            w_Legal = 1'b1;
            w_Op    = ALU_LUI;
            w_Op2   = {12'd0, i_Instr[31:12]};
         end
         OPC_AUIPC: begin
            w_Legal = 1'b1;
            w_Op    = ALU_AUIPC;
            w_Op1   = i_PC;
            w_Op2   = {12'd0, i_Instr[31:12]};
         end
         default: begin
            w_Legal = 1'b0;
         end
      endcase
   end

   assign o_Operation = w_Legal ? w_Op  : ALU_ADD;
   assign o_Op1       = w_Legal ? w_Op1 : '0;
   assign o_Op2       = w_Legal ? w_Op2 : '0;
   assign o_Rd        = i_Instr[11:7];
   assign o_RegWrite  = w_Legal && (i_Instr[11:7] != 5'd0);
   assign o_Illegal   = !w_Legal;

endmodule

// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage
// Registered valid/ready stage between register-file read and the ALU, with a
// two-entry skid buffer so o_Ready comes straight from a flop.
//   i_Clk, i_Rst_n          : clock, async active-low reset
//   i_Flush                 : drop every buffered entry (wins over transfers)
//   i_Valid / o_Ready       : upstream handshake
//   i_Instr, i_PC,
//   i_Rs1Data, i_Rs2Data    : entry to decode
//   o_Valid / i_Ready       : downstream handshake
//   o_Operation, o_Op1,
//   o_Op2, o_Rd,
//   o_RegWrite, o_Illegal   : decoded entry presented to the ALU
// ---------------------------------------------------------------------------
module alu_issue_stage
   import alu_pkg::*;
#(
   parameter int WORD_SIZE = 32
)
(
   input  logic                 i_Clk,
   input  logic                 i_Rst_n,
   input  logic                 i_Flush,
   input  logic                 i_Valid,
   output logic                 o_Ready,
   input  logic [31:0]          i_Instr,
   input  logic [WORD_SIZE-1:0] i_PC,
   input  logic [WORD_SIZE-1:0] i_Rs1Data,
   input  logic [WORD_SIZE-1:0] i_Rs2Data,
   output logic                 o_Valid,
   input  logic                 i_Ready,
   output logic [3:0]           o_Operation,
   output logic [WORD_SIZE-1:0] o_Op1,
   output logic [WORD_SIZE-1:0] o_Op2,
   output logic [4:0]           o_Rd,
   output logic                 o_RegWrite,
   output logic                 o_Illegal
);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_TWO   = 2'd2
   } state_t;

   state_t      r_State;
   state_t      w_NextState;
   logic        r_Valid;
   logic        r_Ready;
   issue_t      r_Out;
   issue_t      r_Skid;
   issue_t      w_Dec;
   logic        w_In;
   logic        w_Out;
   logic        w_LoadOut;
   logic        w_SkidToOut;
   logic        w_LoadSkid;
   logic [3:0]  w_DecOp;
   logic [31:0] w_DecOp1;
   logic [31:0] w_DecOp2;
   logic [4:0]  w_DecRd;
   logic        w_DecRegWrite;
   logic        w_DecIllegal;

   alu_op_decoder u_Decoder (
      .i_Instr     (i_Instr),
      .i_PC        (i_PC),
      .i_Rs1Data   (i_Rs1Data),
      .i_Rs2Data   (i_Rs2Data),
      .o_Operation (w_DecOp),
      .o_Op1       (w_DecOp1),
      .o_Op2       (w_DecOp2),
      .o_Rd        (w_DecRd),
      .o_RegWrite  (w_DecRegWrite),
      .o_Illegal   (w_DecIllegal)
   );

   assign w_Dec = '{op: alu_op_t'(w_DecOp), op1: w_DecOp1, op2: w_DecOp2,
                    rd: w_DecRd, regWrite: w_DecRegWrite, illegal: w_DecIllegal};

   assign w_In  = i_Valid && r_Ready;
   assign w_Out = r_Valid && i_Ready;

   // Occupancy control. A new entry goes to the output register unless that
   // register is held by backpressure, in which case it parks in the skid.
   always_comb begin
      w_NextState = r_State;
      w_LoadOut   = 1'b0;
      w_SkidToOut = 1'b0;
      w_LoadSkid  = 1'b0;
      case (r_State)
         S_EMPTY: begin
            if (w_In) begin
               w_NextState = S_ONE;
               w_LoadOut   = 1'b1;
            end
         end
         S_ONE: begin
            if (w_In && !w_Out) begin
               w_NextState = S_TWO;
               w_LoadSkid  = 1'b1;
            end else if (w_Out && !w_In) begin
               w_NextState = S_EMPTY;
            end else if (w_In && w_Out) begin
               w_LoadOut   = 1'b1;
            end
         end
         S_TWO: begin
            if (w_Out) begin
               w_NextState = S_ONE;
               w_SkidToOut = 1'b1;
            end
         end
         default: begin
            w_NextState = S_EMPTY;
         end
      endcase
      if (i_Flush) begin
         w_NextState = S_EMPTY;
         w_LoadOut   = 1'b0;
         w_SkidToOut = 1'b0;
         w_LoadSkid  = 1'b0;
      end
   end

   // Handshake flags are registered from the next state so neither output
   // depends combinationally on the far-side handshake.
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_State <= S_EMPTY;
         r_Valid <= 1'b0;
         r_Ready <= 1'b1;
      end else begin
         r_State <= w_NextState;
         r_Valid <= (w_NextState != S_EMPTY);
         r_Ready <= (w_NextState != S_TWO);
      end
   end

   // Entry storage; the output register only changes on a load, so it stays
   // stable while the ALU is stalling us.
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_Out  <= '0;
         r_Skid <= '0;
      end else begin
         if (w_LoadOut) begin
            r_Out <= w_Dec;
         end else if (w_SkidToOut) begin
            r_Out <= r_Skid;
         end
         if (w_LoadSkid) begin
            r_Skid <= w_Dec;
         end
      end
   end

   assign o_Valid     = r_Valid;
   assign o_Ready     = r_Ready;
   assign o_Operation = r_Out.op;
   assign o_Op1       = r_Out.op1;
   assign o_Op2       = r_Out.op2;
   assign o_Rd        = r_Out.rd;
   assign o_RegWrite  = r_Out.regWrite;
   assign o_Illegal   = r_Out.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage. Instructions are built from mnemonic
// choices so the expected ALU record is known from the instruction's meaning,
// pushed at acceptance, and compared when the DUT hands an entry downstream.
module tb_alu_issue_stage;

   localparam logic [3:0] E_ADD = 4'd0,  E_SUB = 4'd1,  E_SLL = 4'd2,  E_SLT = 4'd3;
   localparam logic [3:0] E_SLTU = 4'd4, E_XOR = 4'd5,  E_SRL = 4'd6,  E_SRA = 4'd7;
   localparam logic [3:0] E_OR = 4'd8,   E_AND = 4'd9,  E_LUI = 4'd10, E_AUIPC = 4'd11;

   typedef struct packed {
      logic [3:0]  op;
      logic [31:0] op1;
      logic [31:0] op2;
      logic [4:0]  rd;
      logic        rw;
      logic        ill;
   } exp_t;

   logic        i_Clk;
   logic        i_Rst_n;
   logic        i_Flush;
   logic        i_Valid;
   logic        o_Ready;
   logic [31:0] i_Instr;
   logic [31:0] i_PC;
   logic [31:0] i_Rs1Data;
   logic [31:0] i_Rs2Data;
   logic        o_Valid;
   logic        i_Ready;
   logic [3:0]  o_Operation;
   logic [31:0] o_Op1;
   logic [31:0] o_Op2;
   logic [4:0]  o_Rd;
   logic        o_RegWrite;
   logic        o_Illegal;

   int   checks = 0;
   int   errors = 0;
   exp_t q[$];
   exp_t monExp;
   bit   randReady = 0;

   alu_issue_stage #(.WORD_SIZE(32)) dut (
      .i_Clk       (i_Clk),
      .i_Rst_n     (i_Rst_n),
      .i_Flush     (i_Flush),
      .i_Valid     (i_Valid),
      .o_Ready     (o_Ready),
      .i_Instr     (i_Instr),
      .i_PC        (i_PC),
      .i_Rs1Data   (i_Rs1Data),
      .i_Rs2Data   (i_Rs2Data),
      .o_Valid     (o_Valid),
      .i_Ready     (i_Ready),
      .o_Operation (o_Operation),
      .o_Op1       (o_Op1),
      .o_Op2       (o_Op2),
      .o_Rd        (o_Rd),
      .o_RegWrite  (o_RegWrite),
      .o_Illegal   (o_Illegal)
   );

   initial i_Clk = 1'b0;
   always #5 i_Clk = ~i_Clk;

   function automatic exp_t outNow();
      return '{op: o_Operation, op1: o_Op1, op2: o_Op2, rd: o_Rd, rw: o_RegWrite, ill: o_Illegal};
   endfunction

   task automatic checkOutput(input string name, input logic [74:0] act, input logic [74:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Monitor: an entry leaves the stage on a clock edge where o_Valid and
   // i_Ready are both high and no flush is discarding it.
   always @(negedge i_Clk) begin
      if (i_Rst_n && o_Valid && i_Ready && !i_Flush) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_output actual=%h required=none", outNow());
         end else begin
            monExp = q.pop_front();
            checkOutput("transfer_out", outNow(), monExp);
         end
      end
   end

   // Random downstream backpressure during the random phase only.
   always @(posedge i_Clk) begin
      #1;
      if (randReady) i_Ready = ($urandom_range(0, 3) != 0);
   end

   // Build an instruction from a mnemonic class and the record the ALU must see.
   function automatic void makeInstr(input int kind, input logic [31:0] pc,
                                     input logic [31:0] rs1v, input logic [31:0] rs2v,
                                     output logic [31:0] instr, output exp_t e);
      logic [4:0]  rd, rs1f, rs2f, shamt;
      logic [6:0]  f7;
      logic [2:0]  f3;
      logic [11:0] imm12;
      logic [19:0] imm20;
      int          sel;
      rd = 5'($urandom); rs1f = 5'($urandom); rs2f = 5'($urandom);
      shamt = 5'($urandom); imm12 = 12'($urandom); imm20 = 20'($urandom);
      e = '0;
      e.rd = rd;
      case (kind)
         0: begin
            sel = $urandom_range(0, 9);
            f7 = 7'h00;
            case (sel)
               0: begin f3 = 3'd0; e.op = E_ADD; end
               1: begin f3 = 3'd0; f7 = 7'h20; e.op = E_SUB; end
               2: begin f3 = 3'd1; e.op = E_SLL; end
               3: begin f3 = 3'd2; e.op = E_SLT; end
               4: begin f3 = 3'd3; e.op = E_SLTU; end
               5: begin f3 = 3'd4; e.op = E_XOR; end
               6: begin f3 = 3'd5; e.op = E_SRL; end
               7: begin f3 = 3'd5; f7 = 7'h20; e.op = E_SRA; end
               8: begin f3 = 3'd6; e.op = E_OR; end
               default: begin f3 = 3'd7; e.op = E_AND; end
            endcase
            instr = {f7, rs2f, rs1f, f3, rd, 7'b0110011};
            e.op1 = rs1v; e.op2 = rs2v;
         end
         1: begin
            sel = $urandom_range(0, 5);
            case (sel)
               0: begin f3 = 3'd0; e.op = E_ADD; end
               1: begin f3 = 3'd2; e.op = E_SLT; end
               2: begin f3 = 3'd3; e.op = E_SLTU; end
               3: begin f3 = 3'd4; e.op = E_XOR; end
               4: begin f3 = 3'd6; e.op = E_OR; end
               default: begin f3 = 3'd7; e.op = E_AND; end
            endcase
            instr = {imm12, rs1f, f3, rd, 7'b0010011};
            e.op1 = rs1v;
            e.op2 = 32'(signed'(imm12));
         end
         2: begin
            sel = $urandom_range(0, 2);
            case (sel)
               0: begin f3 = 3'd1; f7 = 7'h00; e.op = E_SLL; end
               1: begin f3 = 3'd5; f7 = 7'h00; e.op = E_SRL; end
               default: begin f3 = 3'd5; f7 = 7'h20; e.op = E_SRA; end
            endcase
            instr = {f7, shamt, rs1f, f3, rd, 7'b0010011};
            e.op1 = rs1v; e.op2 = 32'(shamt);
         end
         3: begin
            instr = {imm20, rd, 7'b0110111};
            e.op = E_LUI; e.op1 = 32'd0; e.op2 = 32'(imm20);
         end
         4: begin
            instr = {imm20, rd, 7'b0010111};
            e.op = E_AUIPC; e.op1 = pc; e.op2 = 32'(imm20);
         end
         default: begin
            sel = $urandom_range(0, 5);
            case (sel)
               0: instr = {imm12, rs1f, 3'd0, rd, 7'b1110011};
               1: begin
                  do f3 = 3'($urandom); while (f3 == 3'd0 || f3 == 3'd5);
                  instr = {7'h20, rs2f, rs1f, f3, rd, 7'b0110011};
               end
               2: instr = {7'h01, rs2f, rs1f, 3'($urandom), rd, 7'b0110011};
               3: instr = {7'h20, shamt, rs1f, 3'd1, rd, 7'b0010011};
               4: instr = {7'h01, shamt, rs1f, 3'd5, rd, 7'b0010011};
               default: instr = {imm12, rs1f, 3'd2, rd, 7'b0000011};
            endcase
            e.op = E_ADD; e.op1 = 32'd0; e.op2 = 32'd0; e.ill = 1'b1;
         end
      endcase
      e.rw = !e.ill && (rd != 5'd0);
   endfunction

   // One clock of upstream drive; entered and left just after a rising edge.
   task automatic driveCycle(input logic valid, input logic [31:0] instr, input logic [31:0] pc,
                             input logic [31:0] rs1, input logic [31:0] rs2, input exp_t e,
                             output bit acc);
      i_Valid = valid; i_Instr = instr; i_PC = pc; i_Rs1Data = rs1; i_Rs2Data = rs2;
      @(negedge i_Clk);
      acc = valid && o_Ready && !i_Flush;
      if (acc) q.push_back(e);
      @(posedge i_Clk);
      #1;
      i_Valid = 1'b0;
   endtask

   task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] pc,
                                input logic [31:0] rs1, input logic [31:0] rs2, input exp_t e);
      bit acc;
      int n;
      acc = 0;
      n = 0;
      while (!acc && n < 50) begin
         driveCycle(1'b1, instr, pc, rs1, rs2, e, acc);
         n++;
      end
      if (!acc) begin
         checks++;
         errors++;
         $display("[TB] FAIL accept_timeout actual=not_accepted required=accepted");
      end
   endtask

   task automatic idle(input int n);
      bit acc;
      for (int i = 0; i < n; i++) driveCycle(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, '0, acc);
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      exp_t        e;
      logic [31:0] instr, pc, rs1, rs2;
      bit          acc;

      i_Rst_n = 1'b0; i_Flush = 1'b0; i_Valid = 1'b0; i_Ready = 1'b1;
      i_Instr = '0; i_PC = '0; i_Rs1Data = '0; i_Rs2Data = '0;
      #12;
      checkOutput("reset_valid", o_Valid, 1'b0);
      checkOutput("reset_ready", o_Ready, 1'b1);
      checkOutput("reset_outputs", outNow(), '0);
      @(posedge i_Clk); #1;
      i_Rst_n = 1'b1;
      idle(1);

      $display("[TB] directed decode");
      applyStimulus(32'h002081B3, 32'h0, 32'd5, 32'd7, '{E_ADD, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0});
      checkOutput("latency_valid", o_Valid, 1'b1);
      applyStimulus(32'h40208133, 32'h0, 32'd20, 32'd9, '{E_SUB, 32'd20, 32'd9, 5'd2, 1'b1, 1'b0});
      applyStimulus(32'h4040D093, 32'h0, 32'h80000000, 32'd0, '{E_SRA, 32'h80000000, 32'd4, 5'd1, 1'b1, 1'b0});
      applyStimulus(32'hFFF00093, 32'h0, 32'd0, 32'd0, '{E_ADD, 32'd0, 32'hFFFFFFFF, 5'd1, 1'b1, 1'b0});
      applyStimulus(32'h123452B7, 32'h0, 32'd11, 32'd0, '{E_LUI, 32'd0, 32'h00012345, 5'd5, 1'b1, 1'b0});
      applyStimulus(32'h00001117, 32'h100, 32'd0, 32'd0, '{E_AUIPC, 32'h100, 32'h1, 5'd2, 1'b1, 1'b0});
      applyStimulus(32'h00000073, 32'h0, 32'd3, 32'd4, '{E_ADD, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1});
      applyStimulus(32'h40209133, 32'h0, 32'd3, 32'd4, '{E_ADD, 32'd0, 32'd0, 5'd2, 1'b0, 1'b1});
      idle(3);

      $display("[TB] backpressure");
      i_Ready = 1'b0;
      driveCycle(1'b1, 32'h002081B3, 0, 32'd1, 32'd2, '{E_ADD, 32'd1, 32'd2, 5'd3, 1'b1, 1'b0}, acc);
      checkOutput("bp_accept1", acc, 1'b1);
      driveCycle(1'b1, 32'h40208133, 0, 32'd8, 32'd3, '{E_SUB, 32'd8, 32'd3, 5'd2, 1'b1, 1'b0}, acc);
      checkOutput("bp_accept2", acc, 1'b1);
      driveCycle(1'b1, 32'h00000073, 0, 32'd0, 32'd0, '{E_ADD, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1}, acc);
      checkOutput("bp_reject3", acc, 1'b0);
      checkOutput("bp_ready_low", o_Ready, 1'b0);
      checkOutput("bp_hold1", outNow(), {E_ADD, 32'd1, 32'd2, 5'd3, 1'b1, 1'b0});
      idle(2);
      checkOutput("bp_hold2", outNow(), {E_ADD, 32'd1, 32'd2, 5'd3, 1'b1, 1'b0});
      i_Ready = 1'b1;
      idle(4);
      checkOutput("bp_drain", 75'(q.size()), 75'd0);

      $display("[TB] flush");
      i_Ready = 1'b0;
      applyStimulus(32'h002081B3, 0, 32'd1, 32'd1, '{E_ADD, 32'd1, 32'd1, 5'd3, 1'b1, 1'b0});
      applyStimulus(32'h002081B3, 0, 32'd2, 32'd2, '{E_ADD, 32'd2, 32'd2, 5'd3, 1'b1, 1'b0});
      i_Flush = 1'b1;
      driveCycle(1'b1, 32'h002081B3, 0, 32'd9, 32'd9, '0, acc);
      i_Flush = 1'b0;
      q.delete();
      checkOutput("flush_two_valid", o_Valid, 1'b0);
      checkOutput("flush_two_ready", o_Ready, 1'b1);
      idle(1);
      checkOutput("flush_two_dropped", o_Valid, 1'b0);
      applyStimulus(32'h002081B3, 0, 32'd4, 32'd4, '{E_ADD, 32'd4, 32'd4, 5'd3, 1'b1, 1'b0});
      i_Flush = 1'b1;
      driveCycle(1'b1, 32'h002081B3, 0, 32'd6, 32'd6, '0, acc);
      i_Flush = 1'b0;
      q.delete();
      checkOutput("flush_one_valid", o_Valid, 1'b0);
      idle(1);
      checkOutput("flush_one_dropped", o_Valid, 1'b0);

      $display("[TB] async reset");
      applyStimulus(32'h002081B3, 0, 32'd1, 32'd2, '{E_ADD, 32'd1, 32'd2, 5'd3, 1'b1, 1'b0});
      applyStimulus(32'h40208133, 0, 32'd3, 32'd4, '{E_SUB, 32'd3, 32'd4, 5'd2, 1'b1, 1'b0});
      #2;
      i_Rst_n = 1'b0;
      #1;
      checkOutput("areset_valid", o_Valid, 1'b0);
      checkOutput("areset_ready", o_Ready, 1'b1);
      checkOutput("areset_outputs", outNow(), '0);
      q.delete();
      @(posedge i_Clk); #1;
      i_Rst_n = 1'b1;
      i_Ready = 1'b1;
      idle(1);

      $display("[TB] random");
      randReady = 1;
      for (int n = 0; n < 400; n++) begin
         pc = $urandom; rs1 = $urandom; rs2 = $urandom;
         makeInstr($urandom_range(0, 5), pc, rs1, rs2, instr, e);
         if ($urandom_range(0, 39) == 0) begin
            i_Flush = 1'b1;
            driveCycle(1'($urandom), instr, pc, rs1, rs2, e, acc);
            i_Flush = 1'b0;
            q.delete();
         end else begin
            applyStimulus(instr, pc, rs1, rs2, e);
            if ($urandom_range(0, 3) == 0) idle(1);
         end
      end
      randReady = 0;
      #2;
      i_Ready = 1'b1;
      idle(5);
      checkOutput("final_drain", 75'(q.size()), 75'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
